// File: rtl/id_ex_stage.sv
// ID/EX register and operand select for the ALU; MEM/WB forwarding and a load-use bubble.
// Latency: accepted instruction presents ALU operands 1 cycle later; out_ready low holds everything.
module id_ex_stage #(
    parameter int         XLEN    = 32,
    parameter int         REG_AW  = 5,
    parameter logic [3:0] ALU_XXX = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic              in_rs1_used,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic              in_rs2_used,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_asel,
    input  logic              in_bsel,
    input  logic [3:0]        in_alu_op,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_reg_we,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              fwd_mem_we,
    input  logic [REG_AW-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]   fwd_mem_data,
    input  logic              fwd_wb_we,
    input  logic [REG_AW-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]   fwd_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_op,
    output logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_we,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [XLEN-1:0]   rs1_dat;
        logic [XLEN-1:0]   rs2_dat;
        logic [XLEN-1:0]   imm;
        logic              asel;
        logic              bsel;
        logic [3:0]        alu_op;
        logic [REG_AW-1:0] rd_addr;
        logic              reg_we;
        logic              mem_read;
        logic              mem_write;
    } hdr_t;

    logic valid_q, valid_d;
    hdr_t held_q, held_d;
    logic advance, load_use;
    logic wb_hit1, wb_hit2;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // MEM beats WB; x0 always reads as zero regardless of what anyone claims to write.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   held_dat,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_rd,
        input logic [XLEN-1:0]   mem_dat,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_dat
    );
        if (addr == '0)                    return '0;
        else if (mem_we && mem_rd == addr) return mem_dat;
        else if (wb_we && wb_rd == addr)   return wb_dat;
        else                               return held_dat;
    endfunction

    always_comb begin
        advance  = !valid_q || out_ready;
        load_use = valid_q && held_q.mem_read && (held_q.rd_addr != '0) &&
                   ((in_rs1_used && in_rs1_addr == held_q.rd_addr) ||
                    (in_rs2_used && in_rs2_addr == held_q.rd_addr));
        in_ready = advance && !load_use && !flush;
        // Regfile write and read land in the same cycle; take the value being written.
        wb_hit1  = fwd_wb_we && (fwd_wb_rd == in_rs1_addr) && (in_rs1_addr != '0);
        wb_hit2  = fwd_wb_we && (fwd_wb_rd == in_rs2_addr) && (in_rs2_addr != '0);
    end

    always_comb begin
        valid_d = valid_q;
        held_d  = held_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (advance && load_use) begin
            valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            valid_d          = 1'b1;
            held_d.pc        = in_pc;
            held_d.rs1_addr  = in_rs1_addr;
            held_d.rs2_addr  = in_rs2_addr;
            held_d.rs1_dat   = wb_hit1 ? fwd_wb_data : in_rs1_data;
            held_d.rs2_dat   = wb_hit2 ? fwd_wb_data : in_rs2_data;
            held_d.imm       = in_imm;
            held_d.asel      = in_asel;
            held_d.bsel      = in_bsel;
            held_d.alu_op    = in_alu_op;
            held_d.rd_addr   = in_rd_addr;
            held_d.reg_we    = in_reg_we;
            held_d.mem_read  = in_mem_read;
            held_d.mem_write = in_mem_write;
        end else if (advance) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            held_q        <= '0;
            held_q.alu_op <= ALU_XXX;
        end else begin
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        fwd_rs1 = fwd_sel(held_q.rs1_addr, held_q.rs1_dat, fwd_mem_we, fwd_mem_rd,
                          fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
        fwd_rs2 = fwd_sel(held_q.rs2_addr, held_q.rs2_dat, fwd_mem_we, fwd_mem_rd,
                          fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    end

    assign out_valid    = valid_q;
    assign alu_a        = held_q.asel ? held_q.pc  : fwd_rs1;
    assign alu_b        = held_q.bsel ? held_q.imm : fwd_rs2;
    assign alu_op       = valid_q ? held_q.alu_op : ALU_XXX;
    assign store_data   = fwd_rs2;
    assign ex_pc        = held_q.pc;
    assign ex_rd_addr   = held_q.rd_addr;
    assign ex_reg_we    = valid_q && held_q.reg_we;
    assign ex_mem_read  = valid_q && held_q.mem_read;
    assign ex_mem_write = valid_q && held_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: retiring instructions are scoreboarded, stalls/resets checked directly.
module tb_id_ex_stage;

    logic        clk, rst, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic        in_rs1_used, in_rs2_used, in_asel, in_bsel;
    logic [3:0]  in_alu_op;
    logic        in_reg_we, in_mem_read, in_mem_write;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b, store_data, ex_pc;
    logic [3:0]  alu_op;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_we, ex_mem_read, ex_mem_write;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, sd, pc;
        logic [4:0]  rd;
        logic [2:0]  ctl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs1_used(in_rs1_used),
        .in_rs2_addr(in_rs2_addr), .in_rs2_used(in_rs2_used),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_asel(in_asel), .in_bsel(in_bsel), .in_alu_op(in_alu_op),
        .in_rd_addr(in_rd_addr), .in_reg_we(in_reg_we), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd),
        .fwd_wb_data(fwd_wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
        .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; out_ready = 1;
        in_pc = 0; in_rs1_addr = 0; in_rs1_used = 0; in_rs2_addr = 0; in_rs2_used = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_asel = 0; in_bsel = 0;
        in_alu_op = 0; in_rd_addr = 0; in_reg_we = 0; in_mem_read = 0; in_mem_write = 0;
        fwd_mem_we = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        fwd_wb_we = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic as,
                         input logic bs, input logic [3:0] op, input logic [4:0] rd,
                         input logic we, input logic mr, input logic mw);
        in_valid = 1; in_pc = pc; in_rs1_addr = r1; in_rs1_used = u1;
        in_rs2_addr = r2; in_rs2_used = u2; in_rs1_data = d1; in_rs2_data = d2;
        in_imm = imm; in_asel = as; in_bsel = bs; in_alu_op = op; in_rd_addr = rd;
        in_reg_we = we; in_mem_read = mr; in_mem_write = mw;
    endtask

    task automatic fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic wwe, input logic [4:0] wrd, input logic [31:0] wdat);
        fwd_mem_we = mwe; fwd_mem_rd = mrd; fwd_mem_data = mdat;
        fwd_wb_we = wwe; fwd_wb_rd = wrd; fwd_wb_data = wdat;
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [2:0] ctl);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.sd = sd; e.pc = pc; e.rd = rd; e.ctl = ctl;
        sb.push_back(e);
    endtask

    // Settle away from the clock edge, then retire against the scoreboard on a handshake.
    task automatic eval_cycle();
        exp_t e;
        #2;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("sb_spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("sb_op", 32'(alu_op), 32'(e.op));
                check_val("sb_alu_a", alu_a, e.a);
                check_val("sb_alu_b", alu_b, e.b);
                check_val("sb_store_data", store_data, e.sd);
                check_val("sb_ex_pc", ex_pc, e.pc);
                check_val("sb_ex_rd", 32'(ex_rd_addr), 32'(e.rd));
                check_val("sb_ctl", 32'({ex_reg_we, ex_mem_read, ex_mem_write}), 32'(e.ctl));
            end
        end
    endtask

    initial begin
        rst = 1;
        idle();
        repeat (2) @(negedge clk);
        #2;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_alu_op", 32'(alu_op), 32'hF);
        check_val("rst_alu_a", alu_a, 32'd0);
        check_val("rst_alu_b", alu_b, 32'd0);
        check_val("rst_store_data", store_data, 32'd0);
        check_val("rst_ctl", 32'({ex_reg_we, ex_mem_read, ex_mem_write}), 32'd0);
        rst = 0;

        // addi x1,x0,5 then add x2,x1,x1 with x1 forwarded from MEM
        @(negedge clk); idle();
        drive(32'h0, 5'd0, 1, 5'd0, 0, 32'h0, 32'h0, 32'd5, 0, 1, 4'd0, 5'd1, 1, 0, 0);
        push_exp(4'd0, 32'd0, 32'd5, 32'd0, 32'h0, 5'd1, 3'b100);
        eval_cycle();
        check_val("addi_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); idle();
        drive(32'h4, 5'd1, 1, 5'd1, 1, 32'hAA, 32'hAA, 32'h0, 0, 0, 4'd0, 5'd2, 1, 0, 0);
        push_exp(4'd0, 32'd5, 32'd5, 32'd5, 32'h4, 5'd2, 3'b100);
        eval_cycle();
        @(negedge clk); idle(); fwd(1, 5'd1, 32'd5, 0, 5'd0, 32'd0);
        eval_cycle();

        // MEM (7) must beat WB (9) for x3
        @(negedge clk); idle();
        drive(32'h8, 5'd3, 1, 5'd0, 0, 32'h11, 32'h0, 32'h10, 0, 1, 4'd1, 5'd5, 1, 0, 0);
        push_exp(4'd1, 32'd7, 32'h10, 32'd0, 32'h8, 5'd5, 3'b100);
        eval_cycle();
        @(negedge clk); idle(); fwd(1, 5'd3, 32'd7, 1, 5'd3, 32'd9);
        eval_cycle();

        // store captures rs2 from a same-cycle WB write
        @(negedge clk); idle(); fwd(0, 5'd0, 32'd0, 1, 5'd7, 32'h77);
        drive(32'hC, 5'd6, 1, 5'd7, 1, 32'h1, 32'h2, 32'h20, 0, 1, 4'd0, 5'd0, 0, 0, 1);
        push_exp(4'd0, 32'h1, 32'h20, 32'h77, 32'hC, 5'd0, 3'b001);
        eval_cycle();
        @(negedge clk); idle();
        eval_cycle();

        // lw x4, then dependent: one bubble, load data from WB
        @(negedge clk); idle();
        drive(32'h10, 5'd2, 1, 5'd0, 0, 32'h1000, 32'h0, 32'd8, 0, 1, 4'd0, 5'd4, 1, 1, 0);
        push_exp(4'd0, 32'h1000, 32'd8, 32'd0, 32'h10, 5'd4, 3'b110);
        eval_cycle();
        @(negedge clk); idle();
        drive(32'h14, 5'd4, 1, 5'd0, 1, 32'h0, 32'h0, 32'h0, 0, 0, 4'd0, 5'd9, 1, 0, 0);
        push_exp(4'd0, 32'hDEADBEEF, 32'd0, 32'd0, 32'h14, 5'd9, 3'b100);
        eval_cycle();
        check_val("lu_in_ready_stall", 32'(in_ready), 32'd0);
        @(negedge clk);
        eval_cycle();
        check_val("lu_bubble_valid", 32'(out_valid), 32'd0);
        check_val("lu_bubble_op", 32'(alu_op), 32'hF);
        check_val("lu_in_ready_after", 32'(in_ready), 32'd1);
        @(negedge clk); idle(); fwd(0, 5'd0, 32'd0, 1, 5'd4, 32'hDEADBEEF);
        eval_cycle();

        // three-cycle backpressure freezes outputs, then flush kills the held instruction
        @(negedge clk); idle();
        drive(32'h20, 5'd11, 1, 5'd12, 1, 32'h123, 32'h456, 32'h0, 0, 0, 4'd3, 5'd10, 1, 0, 0);
        eval_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle(); out_ready = 0;
            drive(32'h24, 5'd1, 1, 5'd2, 1, 32'h5, 32'h6, 32'h0, 0, 0, 4'd2, 5'd7, 1, 0, 0);
            eval_cycle();
            check_val("bp_out_valid", 32'(out_valid), 32'd1);
            check_val("bp_alu_a", alu_a, 32'h123);
            check_val("bp_alu_b", alu_b, 32'h456);
            check_val("bp_alu_op", 32'(alu_op), 32'd3);
            check_val("bp_ex_pc", ex_pc, 32'h20);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk); out_ready = 0; flush = 1;
        eval_cycle();
        check_val("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); idle();
        eval_cycle();
        check_val("flush_out_valid", 32'(out_valid), 32'd0);
        check_val("flush_reg_we", 32'(ex_reg_we), 32'd0);
        check_val("flush_alu_op", 32'(alu_op), 32'hF);

        // load-use while EX/MEM is stalled: hold first, bubble only once it drains
        @(negedge clk); idle();
        drive(32'h30, 5'd0, 1, 5'd0, 0, 32'h0, 32'h0, 32'h40, 0, 1, 4'd0, 5'd13, 1, 1, 0);
        push_exp(4'd0, 32'd0, 32'h40, 32'd0, 32'h30, 5'd13, 3'b110);
        eval_cycle();
        @(negedge clk); idle(); out_ready = 0;
        drive(32'h34, 5'd13, 1, 5'd13, 1, 32'h9, 32'h9, 32'h0, 0, 0, 4'd0, 5'd14, 1, 0, 0);
        push_exp(4'd0, 32'h1234, 32'h1234, 32'h1234, 32'h34, 5'd14, 3'b100);
        eval_cycle();
        check_val("lu_bp_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); out_ready = 1;
        eval_cycle();
        check_val("lu_bp_held_valid", 32'(out_valid), 32'd1);
        check_val("lu_bp_in_ready2", 32'(in_ready), 32'd0);
        @(negedge clk);
        eval_cycle();
        check_val("lu_bp_bubble", 32'(out_valid), 32'd0);
        check_val("lu_bp_in_ready3", 32'(in_ready), 32'd1);
        @(negedge clk); idle(); fwd(0, 5'd0, 32'd0, 1, 5'd13, 32'h1234);
        eval_cycle();

        // x0 is never forwarded; auipc selects the PC
        @(negedge clk); idle(); fwd(0, 5'd0, 32'd0, 1, 5'd0, 32'h55);
        drive(32'h40, 5'd0, 1, 5'd0, 1, 32'h99, 32'h99, 32'h0, 0, 0, 4'd0, 5'd15, 1, 0, 0);
        push_exp(4'd0, 32'd0, 32'd0, 32'd0, 32'h40, 5'd15, 3'b100);
        eval_cycle();
        @(negedge clk); idle(); fwd(1, 5'd0, 32'h55, 1, 5'd0, 32'h55);
        drive(32'h100, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0, 32'h3000, 1, 1, 4'd0, 5'd16, 1, 0, 0);
        push_exp(4'd0, 32'h100, 32'h3000, 32'd0, 32'h100, 5'd16, 3'b100);
        eval_cycle();
        @(negedge clk); idle();
        eval_cycle();

        // asynchronous reset while an instruction is held
        @(negedge clk); idle();
        drive(32'h200, 5'd0, 1, 5'd0, 0, 32'h0, 32'h0, 32'd1, 0, 1, 4'd5, 5'd3, 1, 0, 0);
        eval_cycle();
        @(negedge clk); idle(); out_ready = 0;
        eval_cycle();
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'd0);
        check_val("async_rst_alu_op", 32'(alu_op), 32'hF);
        check_val("async_rst_alu_b", alu_b, 32'd0);
        check_val("async_rst_ex_pc", ex_pc, 32'd0);
        check_val("async_rst_reg_we", 32'(ex_reg_we), 32'd0);
        @(negedge clk); rst = 0;

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
